result_collector: RTL and testbench

//  Sits between the child Processor array and the parent core in MultiCore.

---
 rtl/result_collector.sv | 130 +++++++++++++
 tb/tb_result_collector.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// result_collector: latches each child core's (val_1, val_2) result, serves two random-access
// read ports, and once every child has reported scans sequentially for the minimum val_1.
// Ports: clk_i / rst_ni (async, active-low); core_flag_i, core_val_1_i, core_val_2_i carry child
// results (core i at [i*DATA_W +: DATA_W]); clear_i starts a new round; rd_addr_*_i / rd_val_*_o
// are the parent read ports; all_done_o, best_val_o, best_pos_o, best_core_o present the winner;
// timed_out_o flags a watchdog-ended round.
// Optional watchdog: define RC_TIMEOUT_EN to enable the TIMEOUT_CYC round timeout.
module result_collector #(
  parameter int NUM_CORES   = 30,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 5,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_CORES-1:0]        core_flag_i,
  input  logic [NUM_CORES*DATA_W-1:0] core_val_1_i,
  input  logic [NUM_CORES*DATA_W-1:0] core_val_2_i,
  input  logic                        clear_i,
  input  logic [IDX_W-1:0]            rd_addr_1_i,
  input  logic [IDX_W-1:0]            rd_addr_2_i,
  output logic [DATA_W-1:0]           rd_val_1_o,
  output logic [DATA_W-1:0]           rd_val_2_o,
  output logic                        all_done_o,
  output logic [DATA_W-1:0]           best_val_o,
  output logic [DATA_W-1:0]           best_pos_o,
  output logic [IDX_W-1:0]            best_core_o,
  output logic                        timed_out_o
);
  typedef enum logic [1:0] {COLLECT, SCAN, DONE} state_e;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CORES - 1);
  localparam logic [IDX_W:0]   NC   = (IDX_W + 1)'(NUM_CORES);
  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      val_1_q [NUM_CORES];
  logic [DATA_W-1:0]      val_2_q [NUM_CORES];
  logic [NUM_CORES-1:0]   captured_q, captured_d, take;
  logic [IDX_W-1:0]       scan_idx_q, scan_idx_d, best_core_q, best_core_d;
  logic [DATA_W-1:0]      best_val_q, best_val_d, best_pos_q, best_pos_d;
  logic                   timed_out_q, timed_out_d, expire;
  // clear beats capture; a still-high flag is picked up on the following edge
  assign take = (state_q == COLLECT && !clear_i) ? core_flag_i & ~captured_q : '0;
`ifdef RC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  // armed by the first capture of the round, then counts every edge spent in COLLECT
  assign expire = run_q && cnt_q == CNT_W'(TIMEOUT_CYC - 1) && !(&captured_q);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (clear_i || state_q != COLLECT) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= run_q | (|take);
      cnt_q <= run_q ? cnt_q + 1'b1 : cnt_q;
    end
`else
  assign expire = TIMEOUT_CYC < 0;
`endif
  always_comb begin
    state_d     = state_q;
    captured_d  = captured_q | take;
    scan_idx_d  = scan_idx_q;
    best_val_d  = best_val_q;
    best_pos_d  = best_pos_q;
    best_core_d = best_core_q;
    timed_out_d = timed_out_q;
    if (clear_i) begin
      state_d     = COLLECT;
      captured_d  = '0;
      timed_out_d = 1'b0;
    end else if (state_q == COLLECT && (&captured_q || expire)) begin
      state_d     = SCAN;
      scan_idx_d  = '0;
      best_val_d  = '1;
      best_pos_d  = '0;
      best_core_d = '0;
      timed_out_d = expire;
    end else if (state_q == SCAN) begin
      // strict compare keeps the lowest index on ties; uncaptured slots only occur after a timeout
      if (captured_q[scan_idx_q] && val_1_q[scan_idx_q] < best_val_q) begin
        best_val_d  = val_1_q[scan_idx_q];
        best_pos_d  = val_2_q[scan_idx_q];
        best_core_d = scan_idx_q;
      end
      scan_idx_d = scan_idx_q + 1'b1;
      state_d    = (scan_idx_q == LAST) ? DONE : SCAN;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q     <= COLLECT;
      captured_q  <= '0;
      scan_idx_q  <= '0;
      best_val_q  <= '0;
      best_pos_q  <= '0;
      best_core_q <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      captured_q  <= captured_d;
      scan_idx_q  <= scan_idx_d;
      best_val_q  <= best_val_d;
      best_pos_q  <= best_pos_d;
      best_core_q <= best_core_d;
      timed_out_q <= timed_out_d;
    end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        val_1_q[i] <= '0;
        val_2_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++)
        if (take[i]) begin
          val_1_q[i] <= core_val_1_i[i*DATA_W +: DATA_W];
          val_2_q[i] <= core_val_2_i[i*DATA_W +: DATA_W];
        end
    end
  assign rd_val_1_o  = ({1'b0, rd_addr_1_i} < NC) ? val_1_q[rd_addr_1_i] : '0;
  assign rd_val_2_o  = ({1'b0, rd_addr_2_i} < NC) ? val_2_q[rd_addr_2_i] : '0;
  assign all_done_o  = state_q == DONE;
  assign best_val_o  = best_val_q;
  assign best_pos_o  = best_pos_q;
  assign best_core_o = best_core_q;
  assign timed_out_o = timed_out_q;
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: randomized scenarios checked against an argmin reference model of the collector
module tb_result_collector;
  localparam int N  = 30;
  localparam int W  = 32;
  localparam int IW = 5;
  logic            clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [N-1:0]    flag = '0;
  logic [W-1:0]    v1 [N];
  logic [W-1:0]    v2 [N];
  logic [N*W-1:0]  v1_bus, v2_bus;
  logic [IW-1:0]   a1 = '0, a2 = '0;
  logic [W-1:0]    r1, r2, bv, bp;
  logic [IW-1:0]   bc;
  logic            done, tmo;
  logic [W-1:0]    m_v1 [N];
  logic [W-1:0]    m_v2 [N];
  logic [N-1:0]    m_cap = '0;
  int              total = 0, passed = 0;
  always #5 clk = ~clk;
  always_comb
    for (int i = 0; i < N; i++) begin
      v1_bus[i*W +: W] = v1[i];
      v2_bus[i*W +: W] = v2[i];
    end
  result_collector #(.NUM_CORES(N), .DATA_W(W), .IDX_W(IW), .TIMEOUT_CYC(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .core_flag_i(flag), .core_val_1_i(v1_bus), .core_val_2_i(v2_bus),
    .clear_i(clear), .rd_addr_1_i(a1), .rd_addr_2_i(a2), .rd_val_1_o(r1), .rd_val_2_o(r2),
    .all_done_o(done), .best_val_o(bv), .best_pos_o(bp), .best_core_o(bc), .timed_out_o(tmo)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // model: a slot takes the input values when its flag is raised in an open round
  task automatic raise(input int i);
    flag[i] = 1'b1;
    if (!m_cap[i]) begin
      m_v1[i]  = v1[i];
      m_v2[i]  = v2[i];
      m_cap[i] = 1'b1;
    end
  endtask
  // winner = smallest val_1 among captured slots, earliest index among equals
  task automatic model_best(output logic [W-1:0] ev, output logic [W-1:0] ep, output logic [IW-1:0] ec);
    logic found;
    found = 1'b0;
    ev = '1;
    ep = '0;
    ec = '0;
    for (int i = 0; i < N; i++) if (m_cap[i] && m_v1[i] < ev) ev = m_v1[i];
    for (int i = 0; i < N; i++)
      if (!found && m_cap[i] && m_v1[i] == ev) begin
        found = 1'b1;
        ep = m_v2[i];
        ec = IW'(i);
      end
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
  endtask
  task automatic start_round();
    flag = '0;
    m_cap = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask
  task automatic check_best(input string tag);
    logic [W-1:0] ev, ep;
    logic [IW-1:0] ec;
    model_best(ev, ep, ec);
    total++; if (bv !== ev) $display("FAIL %s best_val got=%0d exp=%0d", tag, bv, ev); else passed++;
    total++; if (bc !== ec) $display("FAIL %s best_core got=%0d exp=%0d", tag, bc, ec); else passed++;
    total++; if (bp !== ep) $display("FAIL %s best_pos got=%0h exp=%0h", tag, bp, ep); else passed++;
  endtask
  task automatic test_reset();
    a1 = 5'd3;
    a2 = 5'd29;
    tick(); tick();
    total++; if (done !== 1'b0) $display("FAIL reset all_done got=%0b exp=0", done); else passed++;
    total++; if ({bv, bp, bc} !== '0) $display("FAIL reset best got=%0h/%0h/%0d exp=0", bv, bp, bc); else passed++;
    total++; if (tmo !== 1'b0) $display("FAIL reset timed_out got=%0b exp=0", tmo); else passed++;
    total++; if ({r1, r2} !== '0) $display("FAIL reset rd got=%0h/%0h exp=0", r1, r2); else passed++;
    rst_n = 1'b1;
    tick(); tick();
    total++; if (done !== 1'b0) $display("FAIL reset idle all_done got=%0b exp=0", done); else passed++;
  endtask
  task automatic test_all_flags();
    int n;
    for (int i = 0; i < N; i++) begin
      v1[i] = 100 + i;
      v2[i] = $urandom;
    end
    for (int i = 0; i < N; i++) raise(i);
    wait_done(n);
    total++; if (n != N + 2) $display("FAIL all_flags latency got=%0d exp=%0d", n, N + 2); else passed++;
    check_best("all_flags");
    total++; if (tmo !== 1'b0) $display("FAIL all_flags timed_out got=%0b exp=0", tmo); else passed++;
  endtask
  task automatic test_staggered();
    int n;
    start_round();
    for (int i = 0; i < N; i++) begin
      v1[i] = (i == 17) ? 5 : 50;
      v2[i] = $urandom;
    end
    for (int i = 0; i < N; i++) begin
      raise(i);
      tick();
      // smaller values after capture must not leak into the stored slots
      for (int j = 0; j <= i; j++) v1[j] = $urandom_range(0, 4);
    end
    total++; if (done !== 1'b0) $display("FAIL staggered early all_done got=%0b exp=0", done); else passed++;
    wait_done(n);
    total++; if (n != N + 1) $display("FAIL staggered latency got=%0d exp=%0d", n, N + 1); else passed++;
    check_best("staggered");
  endtask
  task automatic test_tie();
    int n;
    start_round();
    for (int i = 0; i < N; i++) begin
      v1[i] = (i == 3 || i == 9) ? 7 : 20;
      v2[i] = $urandom;
    end
    for (int i = 0; i < N; i++) raise(i);
    wait_done(n);
    total++; if (bc !== 5'd3) $display("FAIL tie best_core got=%0d exp=3", bc); else passed++;
    check_best("tie");
  endtask
  task automatic test_clear_redone();
    int n;
    for (int i = 0; i < N; i++) begin
      v1[i] = $urandom_range(1, 1000);
      v2[i] = $urandom;
    end
    a1 = 5'd4;
    tick(); tick(); tick();
    total++; if (r1 !== m_v1[4]) $display("FAIL done_hold rd_val_1 got=%0d exp=%0d", r1, m_v1[4]); else passed++;
    total++; if (done !== 1'b1) $display("FAIL done_hold all_done got=%0b exp=1", done); else passed++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (done !== 1'b0) $display("FAIL clear all_done got=%0b exp=0", done); else passed++;
    m_cap = '0;
    for (int i = 0; i < N; i++) raise(i);
    wait_done(n);
    total++; if (n != N + 2) $display("FAIL clear latency got=%0d exp=%0d", n, N + 2); else passed++;
    total++; if (r1 !== v1[4]) $display("FAIL clear rd_val_1 got=%0d exp=%0d", r1, v1[4]); else passed++;
    check_best("clear");
  endtask
  task automatic test_reset_mid_scan();
    int n;
    start_round();
    for (int i = 0; i < N; i++) begin
      v1[i] = $urandom_range(1, 1000);
      v2[i] = $urandom;
    end
    for (int i = 0; i < N; i++) raise(i);
    for (int k = 0; k < 12; k++) tick();
    a1 = 5'd5;
    a2 = 5'd6;
    rst_n = 1'b0;
    #1;
    total++; if (done !== 1'b0) $display("FAIL scan_reset all_done got=%0b exp=0", done); else passed++;
    total++; if ({bv, bp, bc} !== '0) $display("FAIL scan_reset best got=%0h/%0h/%0d exp=0", bv, bp, bc); else passed++;
    total++; if ({r1, r2} !== '0) $display("FAIL scan_reset rd got=%0h/%0h exp=0", r1, r2); else passed++;
    tick();
    rst_n = 1'b1;
    m_cap = '0;
    for (int i = 0; i < N; i++) raise(i);
    wait_done(n);
    total++; if (n != N + 2) $display("FAIL scan_reset latency got=%0d exp=%0d", n, N + 2); else passed++;
    check_best("scan_reset");
  endtask
  task automatic test_random_rounds();
    int n;
    logic [W-1:0] e1, e2;
    for (int r = 0; r < 6; r++) begin
      start_round();
      for (int i = 0; i < N; i++) begin
        v1[i] = $urandom_range(0, 31);
        v2[i] = $urandom;
      end
      while (m_cap != '1) begin
        for (int t = 0; t < int'($urandom_range(1, 4)); t++) begin
          int c;
          c = int'($urandom_range(0, N - 1));
          if (!m_cap[c]) raise(c);
        end
        tick();
        for (int j = 0; j < N; j++) if (m_cap[j]) v1[j] = $urandom_range(0, 31);
      end
      wait_done(n);
      total++; if (n != N + 1) $display("FAIL rand%0d latency got=%0d exp=%0d", r, n, N + 1); else passed++;
      check_best($sformatf("rand%0d", r));
      for (int k = 0; k < 4; k++) begin
        a1 = IW'($urandom_range(0, 31));
        a2 = IW'($urandom_range(0, 31));
        #1;
        e1 = (int'(a1) < N) ? m_v1[a1] : '0;
        e2 = (int'(a2) < N) ? m_v2[a2] : '0;
        total++; if (r1 !== e1) $display("FAIL rand%0d rd_val_1[%0d] got=%0h exp=%0h", r, a1, r1, e1); else passed++;
        total++; if (r2 !== e2) $display("FAIL rand%0d rd_val_2[%0d] got=%0h exp=%0h", r, a2, r2, e2); else passed++;
      end
    end
  endtask
  task automatic test_missing_core();
    int n;
    start_round();
    for (int i = 0; i < N; i++) begin
      v1[i] = $urandom_range(10, 500);
      v2[i] = $urandom;
    end
    v1[12] = 1;
    for (int i = 0; i < N; i++) if (i != 12) raise(i);
`ifdef RC_TIMEOUT_EN
    wait_done(n);
    total++; if (done !== 1'b1) $display("FAIL timeout all_done got=%0b exp=1", done); else passed++;
    total++; if (tmo !== 1'b1) $display("FAIL timeout timed_out got=%0b exp=1", tmo); else passed++;
    check_best("timeout");
`else
    n = 0;
    for (int k = 0; k < 150; k++) begin
      tick();
      n += int'(done);
    end
    total++; if (n != 0) $display("FAIL no_timeout all_done cycles got=%0d exp=0", n); else passed++;
    total++; if (tmo !== 1'b0) $display("FAIL no_timeout timed_out got=%0b exp=0", tmo); else passed++;
`endif
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      v1[i] = '0;
      v2[i] = '0;
      m_v1[i] = '0;
      m_v2[i] = '0;
    end
    test_reset();
    test_all_flags();
    test_staggered();
    test_tie();
    test_clear_redone();
    test_reset_mid_scan();
    test_random_rounds();
    test_missing_core();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
